// File: rtl/colmem_pkg.sv
// Shared colmem types and constants: word type, default depth, pointer-width helper.
// Data width defaults to ARCADIA_CORE_DATA_BITS when the section build does not supply it.
`ifndef ARCADIA_CORE_DATA_BITS
`define ARCADIA_CORE_DATA_BITS 32
`endif

package colmem_pkg;
    localparam int COLMEM_DEPTH = 16;
    localparam int COLMEM_WIDTH = `ARCADIA_CORE_DATA_BITS;

    typedef logic [COLMEM_WIDTH-1:0] colmem_word_t;

    function automatic int colmem_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/colmem_ram.sv
// Simple dual-port register array: one write port, one registered read port (1-cycle read).
// No flow control of its own; the caller guarantees enables only on legal addresses.
module colmem_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // Storage itself is never reset; only the output register is.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/colmem_fifo.sv
// Column-memory FIFO: write-to-visible 1 cycle, Read-to-Data 1 cycle; writes dropped while full.
// Define COLMEM_FIFO_OVF_CNT_EN to add a saturating 16-bit ovf_count of dropped writes.
module colmem_fifo
    import colmem_pkg::*;
#(
    parameter int DEPTH = COLMEM_DEPTH,
    parameter int WIDTH = COLMEM_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       wr_ready,
    input  logic                       Read,
    output logic [WIDTH-1:0]           Data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       underflow
`ifdef COLMEM_FIFO_OVF_CNT_EN
    ,
    output logic [15:0]                ovf_count
`endif
);
    localparam int AW = colmem_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_underflow;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_fire;
    logic          w_rd_fire;

    // Status comes from the registered count only, so a same-cycle pop never frees a slot for a write.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_wr_fire = wr_valid && !w_full;
    assign w_rd_fire = Read && !w_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_fire && !w_rd_fire) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_fire && !w_wr_fire) begin
                r_count <= r_count - CW'(1);
            end
            if (Read && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    colmem_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .i_clk     (clock),
        .i_rst     (reset),
        .i_wr_en   (w_wr_fire),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (wr_data),
        .i_rd_en   (w_rd_fire),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (Data)
    );

`ifdef COLMEM_FIFO_OVF_CNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (wr_valid && w_full && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

    assign empty     = w_empty;
    assign full      = w_full;
    assign wr_ready  = !w_full;
    assign count     = r_count;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_colmem_fifo.sv
// Self-checking bench for colmem_fifo against a queue-based reference model.
module tb_colmem_fifo;
    localparam int D  = 16;
    localparam int W  = 8;
    localparam int CW = $clog2(D+1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_ready;
    logic          Read = 1'b0;
    logic [W-1:0]  Data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          underflow;
`ifdef COLMEM_FIFO_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model
    logic [W-1:0] q[$];
    logic [W-1:0] m_data = '0;
    logic         m_unf  = 1'b0;
    logic [15:0]  m_ovf  = '0;

    colmem_fifo #(.DEPTH(D), .WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .Read      (Read),
        .Data      (Data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .underflow (underflow)
`ifdef COLMEM_FIFO_OVF_CNT_EN
        ,
        .ovf_count (ovf_count)
`endif
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
    task automatic drive_cycle(input logic wv, input logic [W-1:0] wd, input logic rd, input logic rst);
        bit was_full;
        bit was_empty;
        wr_valid = wv;
        wr_data  = wd;
        Read     = rd;
        reset    = rst;
        if (rst) begin
            q.delete();
            m_data = '0;
            m_unf  = 1'b0;
            m_ovf  = '0;
        end else begin
            was_full  = (q.size() == D);
            was_empty = (q.size() == 0);
            if (rd && !was_empty) m_data = q.pop_front();
            if (rd && was_empty) m_unf = 1'b1;
            if (wv && !was_full) q.push_back(wd);
            else if (wv && m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
        end
        @(posedge clock);
        #1;
        wr_valid = 1'b0;
        Read     = 1'b0;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        checks++; if (Data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", Data); end
        checks++; if (count !== 0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
`ifdef COLMEM_FIFO_OVF_CNT_EN
        checks++; if (ovf_count !== 16'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", ovf_count); end
`endif
    endtask

    task automatic test_basic();
        logic [W-1:0] words [3];
        int exp_cnt [6];
        words = '{8'hA1, 8'hA2, 8'hA3};
        exp_cnt = '{1, 2, 3, 2, 1, 0};
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, words[i], 1'b0, 1'b0);
            checks++; if (count !== CW'(exp_cnt[i])) begin failures++; $display("FAIL basic_wr_count[%0d] got=%0d exp=%0d", i, count, exp_cnt[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            checks++; if (Data !== words[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, Data, words[i]); end
            checks++; if (count !== CW'(exp_cnt[i+3])) begin failures++; $display("FAIL basic_rd_count[%0d] got=%0d exp=%0d", i, count, exp_cnt[i+3]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL basic_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (Data !== 8'h00) begin failures++; $display("FAIL unf_data got=%h exp=00", Data); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_set got=%b exp=1", underflow); end
        // Write into empty with Read in the same cycle: write wins, pop ignored.
        drive_cycle(1'b1, 8'h5C, 1'b1, 1'b0);
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL unf_wr_rd_count got=%0d exp=1", count); end
        checks++; if (Data !== 8'h00) begin failures++; $display("FAIL unf_wr_rd_data got=%h exp=00", Data); end
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (Data !== 8'h5C) begin failures++; $display("FAIL unf_pop_data got=%h exp=5c", Data); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%b exp=1", underflow); end
    endtask

    task automatic test_full();
        logic [W-1:0] golden[$];
        logic [W-1:0] w;
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            w = W'($urandom_range(0, 254));
            golden.push_back(w);
            drive_cycle(1'b1, w, 1'b0, 1'b0);
        end
        checks++; if (full !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL full_flags got full=%b rdy=%b exp full=1 rdy=0", full, wr_ready); end
        drive_cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (count !== CW'(D)) begin failures++; $display("FAIL full_drop_count got=%0d exp=%0d", count, D); end
`ifdef COLMEM_FIFO_OVF_CNT_EN
        checks++; if (ovf_count !== 16'd1) begin failures++; $display("FAIL full_ovf got=%0d exp=1", ovf_count); end
`endif
        drive_cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++; if (count !== CW'(D-1)) begin failures++; $display("FAIL full_wr_rd_count got=%0d exp=%0d", count, D-1); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_rdy_restore got=%b exp=1", wr_ready); end
        checks++; if (Data !== golden[0]) begin failures++; $display("FAIL full_drain[0] got=%h exp=%h", Data, golden[0]); end
        for (int i = 1; i < D; i++) begin
            drive_cycle(1'b0, '0, 1'b1, 1'b0);
            checks++; if (Data !== golden[i]) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, Data, golden[i]); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        int written = 0;
        int popped  = 0;
        int sz;
        logic rd;
        logic wv;
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 300 && (written < 40 || q.size() > 0); cyc++) begin
            sz = q.size();
            rd = (sz >= 2) || (sz > 0 && written == 40) || (sz == 1 && $urandom_range(0, 1) == 1);
            wv = (written < 40) && (sz < 3 || rd);
            drive_cycle(wv, W'(written + 8'h40), rd, 1'b0);
            if (wv) written++;
            if (rd) popped++;
            checks++; if (count > CW'(3)) begin failures++; $display("FAIL b2b_occupancy got=%0d exp<=3", count); end
            checks++; if (Data !== m_data) begin failures++; $display("FAIL b2b_data got=%h exp=%h", Data, m_data); end
        end
        checks++; if (popped !== 40) begin failures++; $display("FAIL b2b_popped got=%0d exp=40", popped); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, W'($urandom), 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, 1'b1, 1'b1);
        checks++; if (count !== 0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
        checks++; if (Data !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", Data); end
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL rstmid_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_random();
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive_cycle($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 45, $urandom_range(0, 199) == 0);
            checks++; if (Data !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, Data, m_data); end
            checks++; if (count !== CW'(q.size())) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
            checks++; if (empty !== (q.size() == 0) || full !== (q.size() == D) || wr_ready !== (q.size() != D)) begin
                failures++; $display("FAIL rnd_flags cyc=%0d got e=%b f=%b r=%b exp size=%0d", cyc, empty, full, wr_ready, q.size());
            end
            checks++; if (underflow !== m_unf) begin failures++; $display("FAIL rnd_underflow cyc=%0d got=%b exp=%b", cyc, underflow, m_unf); end
`ifdef COLMEM_FIFO_OVF_CNT_EN
            checks++; if (ovf_count !== m_ovf) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%0d exp=%0d", cyc, ovf_count, m_ovf); end
`endif
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_basic();
        test_underflow();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/colmem_fifo.md
# colmem_fifo

Per-column memory buffer at the end-of-section boundary. It is the data source behind the column-memory read port: column cores push hit words in, and the end-of-section reader pops them with a `Read` strobe, sampling `Data`. It is instantiated once per column, `ARCADIA_SECTION_COLUMNS` times per section, and also serves as the reference responder in section-level UVM benches.

## Interface
Parameters:
- `DEPTH`, default 16: number of storage words; power of two, at least 2.
- `WIDTH`, default `` `ARCADIA_CORE_DATA_BITS ``: data word width.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wr_valid`  in  1: write request from the column core.
- `wr_data`  in  WIDTH: write word.
- `wr_ready`  out  1: FIFO can accept a word this cycle (equals `!full`).
- `Read`  in  1: pop strobe from the end-of-section reader.
- `Data`  out  WIDTH: registered read data.
- `empty`  out  1: no stored words.
- `full`  out  1: DEPTH words stored.
- `count`  out  $clog2(DEPTH+1): number of stored words.
- `underflow`  out  1: sticky flag, set by `Read` while `empty`.

## Operation
- Storage is a circular buffer with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate `count` register.
- Write is accepted when `wr_valid && !full`. The word is stored at `wr_ptr`, then `wr_ptr` increments.
- Pop happens when `Read && !empty`. The word at `rd_ptr` is registered into `Data`, then `rd_ptr` increments.
- `Read` while `empty`:
  - no pop; `Data` holds its value; `underflow` is set.
  - `underflow` clears only on `reset`.
- `wr_valid` while `full`:
  - the word is dropped and pointers do not change.
  - `full`/`wr_ready` come from registered state, so a simultaneous pop does not free a slot for the same-cycle write.
- Write and pop in the same cycle with neither blocked: `count` is unchanged and both pointers advance.
- Write into an empty FIFO with `Read` in the same cycle:
  - the write is accepted and the pop is ignored;
  - `underflow` is set, because `empty` was 1 at the edge.
- Status outputs are derived from `count` only: `empty = (count==0)`, `full = (count==DEPTH)`.
- Reset values: `Data=0`, `count=0`, `empty=1`, `full=0`, `wr_ready=1`, `underflow=0`, both pointers 0.
- Reset asserted mid-operation discards all stored words on that edge. Storage contents are not cleared, only made unreachable.

## Timing
- Write-to-visible latency is 1: a write at edge N gives `empty=0` after edge N.
- Read latency is 1: `Read` sampled at edge N puts the popped word on `Data` after edge N. It is held until the next successful pop.
- Back-to-back `Read` on consecutive cycles drains one word per cycle.
- A FIFO that fills on edge N shows `wr_ready=0` after edge N. A pop at edge N+1 restores `wr_ready=1` after N+1.

## Configuration
- `COLMEM_FIFO_OVF_CNT_EN` defined:
  - adds output `ovf_count` (16 bits, reset 0), which increments on each dropped write (`wr_valid && full`);
  - it saturates at 16'hFFFF and does not wrap.
- Undefined: the port and the counter are absent, and dropped writes are silent.

## Structure
- Shared package `colmem_pkg`: `colmem_word_t` (logic [WIDTH-1:0]), the default `COLMEM_DEPTH` constant, and the pointer-width function.
- Sub-module `colmem_ram`: a simple dual-port register array with one write port and one registered read port, so a technology macro can replace it.
- The FIFO top holds pointers, count, flags and the optional counter.

## Test plan
- Reset, then write 0xA1, 0xA2, 0xA3 on consecutive cycles, then `Read` ×3 → `Data` = 0xA1, 0xA2, 0xA3 on the cycles after each `Read`; `empty=1` at the end; `count` sequence 1,2,3,2,1,0.
- Fill DEPTH=16 words, then write 0xFF with `wr_valid` → `full=1`, `wr_ready=0`, word dropped; a full drain returns exactly the first 16 words; with the macro defined, `ovf_count=1`.
- Full FIFO with write and `Read` in the same cycle → pop succeeds, write dropped, `count=15`.
- `Read` on an empty FIFO after reset → `Data` stays 0, `underflow=1`; it remains 1 after later valid traffic.
- Write and read 40 words continuously with occupancy 1–3 → both pointers wrap at least twice, data order is preserved, and `count` is never more than 3.
- Load 5 words, assert `reset` for one cycle with `Read` high → after reset `count=0`, `empty=1`, `Data=0`, `underflow=0`.
